// File: rtl/qracc_pkg.sv
// Shared qracc types: CSR bus payloads, controller trigger states and the
// statistics-counter control word and register offsets.
package qracc_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;

    typedef struct packed {
        logic                  valid;
        logic                  wr;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] data_in;
    } bus_req_t;

    typedef struct packed {
        logic                  ready;
        logic                  rd_data_valid;
        logic [BUS_DATA_W-1:0] data_out;
    } bus_resp_t;

    typedef enum logic [2:0] {
        TRIG_IDLE         = 3'd0,
        TRIG_LOAD_WEIGHTS = 3'd1,
        TRIG_LOAD_ACTS    = 3'd2,
        TRIG_COMPUTE      = 3'd3,
        TRIG_SEQ_ACC      = 3'd4,
        TRIG_WRITEBACK    = 3'd5,
        TRIG_FLUSH        = 3'd6,
        TRIG_DONE         = 3'd7
    } qracc_trigger_t;

    // Field order puts enable at bit 0 and auto_snap at bit 4.
    typedef struct packed {
        logic auto_snap;
        logic saturate;
        logic snapshot;
        logic clear;
        logic enable;
    } stat_ctrl_t;

    localparam int unsigned STAT_CTRL_W = 5;

    localparam logic [7:0] STAT_CTRL_OFS     = 8'h00;
    localparam logic [7:0] STAT_STATUS_OFS   = 8'h04;
    localparam logic [7:0] STAT_INFO_OFS     = 8'h08;
    localparam logic [7:0] STAT_CNT_BASE_OFS = 8'h40;

endpackage

// File: rtl/qracc_stat_counter.sv
// Single performance counter: weighted increment, synchronous clear,
// saturate-or-wrap on carry, combinational carry-out for the sticky flag.
module qracc_stat_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned INC_BITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    input  logic                saturate,
    input  logic [INC_BITS-1:0] inc,
    output logic [WIDTH-1:0]    count,
    output logic                carry_c
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic [SUM_W-1:0] sum_c;

    assign sum_c = {1'b0, count} + SUM_W'(inc);

    // Clear drops this cycle's increment, so it cannot raise a carry either.
    assign carry_c = en & ~clr & sum_c[WIDTH];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (sum_c[WIDTH] && saturate) begin
                count <= '1;
            end else begin
                count <= sum_c[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/qracc_stat_counters.sv
// Performance-counter bank: weighted event counters plus per-trigger-state
// cycle counters, read by the host through snapshots on the CSR bus.
module qracc_stat_counters
    import qracc_pkg::*;
#(
    parameter int unsigned NUM_EVENTS     = 11,
    parameter int unsigned NUM_STATES     = 8,
    parameter int unsigned COUNTER_WIDTH  = 32,
    parameter int unsigned EVENT_INC_BITS = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_EVENTS*EVENT_INC_BITS-1:0] event_inc_i,
    input  logic [2:0]                           state_i,
    input  bus_req_t                             bus_req_i,
    output bus_resp_t                            bus_resp_o,
    output logic                                 overflow_o
);

    localparam int unsigned NUM_CNT = NUM_EVENTS + NUM_STATES;

    if (NUM_CNT > 32) begin : g_cnt_check
        $error("qracc_stat_counters: NUM_EVENTS+NUM_STATES must be <= 32");
    end
    if (COUNTER_WIDTH < 8 || COUNTER_WIDTH > 32) begin : g_width_check
        $error("qracc_stat_counters: COUNTER_WIDTH must be in 8..32");
    end

    stat_ctrl_t             ctrl_q;
    qracc_trigger_t         prev_state_q;
    logic [NUM_CNT-1:0]     sticky_q;
    logic [NUM_CNT-1:0]     sticky_d;
    logic [NUM_CNT-1:0]     carry_vec;
    logic [COUNTER_WIDTH-1:0] cnt   [NUM_CNT];
    logic [COUNTER_WIDTH-1:0] snap_q[NUM_CNT];

    logic        ready_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;

    logic [7:0]  ofs_c;
    logic        wr_c;
    logic        rd_c;
    logic        ctrl_wr_c;
    logic        status_wr_c;
    stat_ctrl_t  ctrl_wdata_c;
    logic        clear_c;
    logic        snap_c;
    logic [5:0]  cnt_idx_c;
    logic [31:0] rd_data_c;
    logic        unused_bus;

    // Request decode; addr[1:0] and addr[31:8] are not part of the window.
    assign ofs_c        = bus_req_i.addr[7:0] & 8'hFC;
    assign wr_c         = bus_req_i.valid & bus_req_i.wr;
    assign rd_c         = bus_req_i.valid & ~bus_req_i.wr;
    assign ctrl_wr_c    = wr_c && (ofs_c == STAT_CTRL_OFS);
    assign status_wr_c  = wr_c && (ofs_c == STAT_STATUS_OFS);
    assign ctrl_wdata_c = stat_ctrl_t'(bus_req_i.data_in[STAT_CTRL_W-1:0]);
    assign cnt_idx_c    = ofs_c[7:2] - 6'd16;
    assign unused_bus   = ^bus_req_i;

    assign clear_c = ctrl_wr_c & ctrl_wdata_c.clear;
    assign snap_c  = (ctrl_wr_c & ctrl_wdata_c.snapshot)
                   | (ctrl_q.auto_snap && (prev_state_q != TRIG_IDLE)
                      && (state_i == TRIG_IDLE));

    for (genvar i = 0; i < NUM_EVENTS; i++) begin : g_evt
        qracc_stat_counter #(
            .WIDTH    (COUNTER_WIDTH),
            .INC_BITS (EVENT_INC_BITS)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .en       (ctrl_q.enable),
            .clr      (clear_c),
            .saturate (ctrl_q.saturate),
            .inc      (event_inc_i[i*EVENT_INC_BITS +: EVENT_INC_BITS]),
            .count    (cnt[i]),
            .carry_c  (carry_vec[i])
        );
    end

    for (genvar j = 0; j < NUM_STATES; j++) begin : g_state
        logic [EVENT_INC_BITS-1:0] inc;
        assign inc = EVENT_INC_BITS'(state_i == 3'(j));

        qracc_stat_counter #(
            .WIDTH    (COUNTER_WIDTH),
            .INC_BITS (EVENT_INC_BITS)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .en       (ctrl_q.enable),
            .clr      (clear_c),
            .saturate (ctrl_q.saturate),
            .inc      (inc),
            .count    (cnt[NUM_EVENTS+j]),
            .carry_c  (carry_vec[NUM_EVENTS+j])
        );
    end

    // New overflows win over a same-cycle write-1-to-clear.
    always_comb begin
        sticky_d = sticky_q;
        if (status_wr_c) begin
            sticky_d = sticky_d & ~bus_req_i.data_in[NUM_CNT-1:0];
        end
        sticky_d = sticky_d | carry_vec;
    end

    // Read mux; snapshot reads see the value held before this edge.
    always_comb begin
        rd_data_c = '0;
        if (ofs_c == STAT_CTRL_OFS) begin
            rd_data_c = 32'({ctrl_q.auto_snap, ctrl_q.saturate, 2'b00, ctrl_q.enable});
        end else if (ofs_c == STAT_STATUS_OFS) begin
            rd_data_c = 32'(sticky_q);
        end else if (ofs_c == STAT_INFO_OFS) begin
            rd_data_c = {10'd0, 6'(COUNTER_WIDTH), 8'(NUM_STATES), 8'(NUM_EVENTS)};
        end else if (ofs_c >= STAT_CNT_BASE_OFS) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (cnt_idx_c == 6'(i)) begin
                    rd_data_c = 32'(snap_q[i]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= '0;
            end
        end else if (snap_c) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q       <= '0;
            prev_state_q <= TRIG_IDLE;
            sticky_q     <= '0;
            overflow_o   <= 1'b0;
            ready_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            if (ctrl_wr_c) begin
                ctrl_q           <= ctrl_wdata_c;
                ctrl_q.clear     <= 1'b0;
                ctrl_q.snapshot  <= 1'b0;
            end
            prev_state_q <= qracc_trigger_t'(state_i);
            sticky_q     <= sticky_d;
            overflow_o   <= |sticky_d;
            ready_q      <= 1'b1;
            rvalid_q     <= rd_c;
            if (rd_c) begin
                rdata_q <= rd_data_c;
            end
        end
    end

    assign bus_resp_o.ready         = ready_q;
    assign bus_resp_o.rd_data_valid = rvalid_q;
    assign bus_resp_o.data_out      = rdata_q;

endmodule
